mem_burst_master: RTL and testbench
===================================

MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 Parameter ADDR_W, default 4: memory address width in bits.
REQ-002 Parameter DATA_W, default 8: memory data width in bits.
REQ-003 Parameter RD_LAT, default 1: number of cycles from a cycle with MEM_READ=1 to the cycle in which MEM_DOUT holds that read's data.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RESET  input  1  reset, asynchronous, active-high.
REQ-006 REQ_VALID  input  1  host burst request valid.
REQ-007 REQ_READY  output  1  master can accept a burst request.
REQ-008 REQ_WR  input  1  burst direction: 1 = write, 0 = read.
REQ-009 REQ_ADDR  input  ADDR_W  burst start address.
REQ-010 REQ_LEN  input  ADDR_W  burst length minus one (0 = 1 beat, max 2^ADDR_W beats).
REQ-011 WDATA  input  DATA_W  host write beat data.
REQ-012 WDATA_VALID  input  1  write beat valid.
REQ-013 WDATA_READY  output  1  master accepts a write beat.
REQ-014 RDATA  output  DATA_W  read beat data.
REQ-015 RDATA_VALID  output  1  RDATA valid for exactly this cycle; the host has no backpressure.
REQ-016 BUSY  output  1  burst in progress.
REQ-017 DONE  output  1  one-cycle pulse marking burst completion.
REQ-018 MEM_ADDR  output  ADDR_W  memory address.
REQ-019 MEM_DIN  output  DATA_W  memory write data.
REQ-020 MEM_READ  output  1  memory read strobe.
REQ-021 MEM_WRITE  output  1  memory write strobe.
REQ-022 MEM_DOUT  input  DATA_W  memory read data.

Function
REQ-023 The FSM SHALL have the states IDLE, WR, RD, DRAIN and FIN.
REQ-024 REQ_READY SHALL be 1 only in IDLE; a request is accepted on an edge where REQ_VALID=1 and REQ_READY=1.
REQ-025 On acceptance, the master SHALL latch the start address into an address pointer, latch REQ_LEN into a beat counter, and go to WR if REQ_WR=1 or RD if REQ_WR=0.
REQ-026 BUSY SHALL be 1 in WR, RD, DRAIN and FIN, and 0 in IDLE.
REQ-027 In WR: WDATA_READY=1, MEM_WRITE=WDATA_VALID, MEM_DIN=WDATA, MEM_ADDR=pointer.
REQ-028 A WR beat SHALL complete only on an edge with WDATA_VALID=1; idle cycles SHALL leave the pointer and counter unchanged.
REQ-029 In RD, MEM_READ=1 and MEM_ADDR=pointer every cycle; each cycle is one issued beat.
REQ-030 Each completed or issued beat SHALL increment the pointer modulo 2^ADDR_W (address 15 wraps to 0) and decrement the counter.
REQ-031 The last WR beat (counter=0) SHALL go to FIN.
REQ-032 The last RD beat SHALL go to DRAIN.
REQ-033 For a read issued in cycle k, the master SHALL register MEM_DOUT in cycle k+RD_LAT, giving RDATA_VALID=1 and RDATA=that data in cycle k+RD_LAT+1.
- Outstanding reads SHALL be tracked with an RD_LAT-deep valid shift register.
- Beat order SHALL be preserved.
REQ-034 DRAIN SHALL go to FIN on the edge after the last read's MEM_DOUT capture, so the final RDATA_VALID coincides with FIN.
REQ-035 In FIN, DONE=1 for one cycle; the next state is IDLE.
REQ-036 A new request SHALL be accepted no earlier than the cycle after FIN.
REQ-037 MEM_READ and MEM_WRITE SHALL never both be 1.
REQ-038 Outside WR and RD:
- MEM_READ=0 and MEM_WRITE=0.
- MEM_ADDR and MEM_DIN hold their last values.
REQ-039 REQ_* inputs SHALL be ignored while BUSY=1.
REQ-040 WDATA_VALID SHALL be ignored outside WR.
REQ-041 All outputs SHALL be registered or decoded from state and registers only; there is no combinational path from host inputs to MEM_READ.
- Exception: MEM_WRITE, WDATA_READY and MEM_DIN in WR, as defined in REQ-027.
REQ-042 Read and write bursts of 2^ADDR_W beats SHALL touch every address exactly once.

Reset
REQ-043 While RESET=1, the master SHALL hold: state=IDLE, REQ_READY=0, BUSY=0, DONE=0, WDATA_READY=0, RDATA_VALID=0, RDATA=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_DIN=0, and pointer, counter and valid pipeline cleared.
REQ-044 On the first edge after RESET deasserts, the master SHALL take IDLE behaviour, with REQ_READY=1.
REQ-045 RESET asserted mid-burst SHALL:
- abort the burst immediately;
- drop in-flight reads (no RDATA_VALID afterwards);
- produce no DONE pulse.

Verification
REQ-046 Single write: REQ_WR=1, ADDR=3, LEN=0, WDATA=0xA5 valid -> one cycle with MEM_WRITE=1, MEM_ADDR=3, MEM_DIN=0xA5; DONE on the following cycle.
REQ-047 Read burst: ADDR=14, LEN=3, memory model preloaded with [14]=0x11, [15]=0x22, [0]=0x33, [1]=0x44 -> MEM_ADDR 14,15,0,1 on consecutive cycles; RDATA 0x11,0x22,0x33,0x44 in order; DONE with the last beat.
REQ-048 Write with stalls: LEN=2, WDATA_VALID pattern 1,0,0,1,1 -> exactly 3 MEM_WRITE pulses at addresses ADDR, ADDR+1, ADDR+2; pointer frozen during the stall cycles.
REQ-049 Full wrap: write LEN=15 from ADDR=8 with data 0..15, then read LEN=15 from ADDR=0 -> RDATA equals 8..15 then 0..7.
REQ-050 Reset mid-read: RESET pulsed after the second RD beat of a LEN=5 burst -> all outputs 0 during reset, no further RDATA_VALID, no DONE, REQ_READY=1 after release.
REQ-051 Protocol checks across all scenarios: MEM_READ&MEM_WRITE never 1; REQ_READY=0 while BUSY=1; exactly one DONE per accepted request.

Source files
------------

// File: rtl/mem_burst_master_if.sv
// Host request/write/read channels plus memory port for mem_burst_master.
// The master modport is the burst engine's view; slave is the host and memory side.
interface mem_burst_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WR;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [ADDR_W-1:0] REQ_LEN;
    logic [DATA_W-1:0] WDATA;
    logic              WDATA_VALID;
    logic              WDATA_READY;
    logic [DATA_W-1:0] RDATA;
    logic              RDATA_VALID;
    logic              BUSY;
    logic              DONE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DIN;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [DATA_W-1:0] MEM_DOUT;

    modport master (
        input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_LEN, WDATA, WDATA_VALID, MEM_DOUT,
        output REQ_READY, WDATA_READY, RDATA, RDATA_VALID, BUSY, DONE,
               MEM_ADDR, MEM_DIN, MEM_READ, MEM_WRITE
    );

    modport slave (
        output REQ_VALID, REQ_WR, REQ_ADDR, REQ_LEN, WDATA, WDATA_VALID, MEM_DOUT,
        input  REQ_READY, WDATA_READY, RDATA, RDATA_VALID, BUSY, DONE,
               MEM_ADDR, MEM_DIN, MEM_READ, MEM_WRITE
    );
endinterface

// File: rtl/mem_burst_master.sv
// Burst engine turning host read/write requests into sequential memory beats
// with wrapping addresses and a fixed-latency read return path.
module mem_burst_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    mem_burst_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, FIN} state_e;

    state_e              state_q, state_d;
    logic                armed_q, armed_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0]   din_hold_q, din_hold_d;
    logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;
    logic                mem_read;

    always_comb begin
        state_d     = state_q;
        armed_d     = 1'b1;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        addr_hold_d = addr_hold_q;
        din_hold_d  = din_hold_q;
        mem_read    = (state_q == RD);

        rd_vld_d      = rd_vld_q << 1;
        rd_vld_d[0]   = mem_read;
        rdata_valid_d = rd_vld_q[RD_LAT-1];
        rdata_d       = rd_vld_q[RD_LAT-1] ? bus.MEM_DOUT : rdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.REQ_VALID && armed_q) begin
                    ptr_d   = bus.REQ_ADDR;
                    cnt_d   = bus.REQ_LEN;
                    state_d = bus.REQ_WR ? WR : RD;
                end
            end
            WR: begin
                addr_hold_d = ptr_q;
                din_hold_d  = bus.WDATA;
                if (bus.WDATA_VALID) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = FIN;
                end
            end
            RD: begin
                addr_hold_d = ptr_q;
                ptr_d       = ptr_q + 1'b1;
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = DRAIN;
            end
            DRAIN: begin
                // Leave once the oldest outstanding read is being captured and nothing trails it.
                if (rd_vld_q[RD_LAT-1] && (rd_vld_d == '0)) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            armed_q       <= 1'b0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            addr_hold_q   <= '0;
            din_hold_q    <= '0;
            rd_vld_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            addr_hold_q   <= addr_hold_d;
            din_hold_q    <= din_hold_d;
            rd_vld_q      <= rd_vld_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // armed_q keeps REQ_READY low while RESET is held, since IDLE is entered asynchronously.
    assign bus.REQ_READY   = (state_q == IDLE) && armed_q;
    assign bus.BUSY        = (state_q != IDLE);
    assign bus.DONE        = (state_q == FIN);
    assign bus.WDATA_READY = (state_q == WR);
    assign bus.MEM_WRITE   = (state_q == WR) && bus.WDATA_VALID;
    assign bus.MEM_READ    = mem_read;
    assign bus.MEM_ADDR    = ((state_q == WR) || (state_q == RD)) ? ptr_q : addr_hold_q;
    assign bus.MEM_DIN     = (state_q == WR) ? bus.WDATA : din_hold_q;
    assign bus.RDATA       = rdata_q;
    assign bus.RDATA_VALID = rdata_valid_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Randomized bench for mem_burst_master: a memory model answers the DUT while a
// reference memory image predicts every write beat, read return and DONE timing.
module tb_mem_burst_master;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic pl_all = 1'b0;

    always #5 CLK = ~CLK;

    mem_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [DATA_W-1:0] ref_mem   [DEPTH];
    logic [DATA_W-1:0] wdata_tbl [DEPTH];
    logic [DATA_W-1:0] mem       [DEPTH];
    logic [DATA_W-1:0] dline     [RD_LAT];

    // Memory device: synchronous write, read data appears RD_LAT cycles after the strobe.
    always @(posedge CLK) begin
        if (pl_all) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
        end else if (bus.MEM_WRITE) begin
            mem[bus.MEM_ADDR] <= bus.MEM_DIN;
        end
        dline[0] <= mem[bus.MEM_ADDR];
        for (int i = 1; i < RD_LAT; i++) dline[i] <= dline[i-1];
    end
    assign bus.MEM_DOUT = dline[RD_LAT-1];

    logic [26:0] outs;
    assign outs = {bus.REQ_READY, bus.BUSY, bus.DONE, bus.WDATA_READY, bus.RDATA_VALID,
                   bus.RDATA, bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_DIN};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Observed activity log, sampled mid-cycle after host inputs have settled.
    int cyc = 0;
    int w_addr[$], w_data[$], w_cyc[$];
    int r_addr[$], r_cyc[$];
    int d_data[$], d_cyc[$];
    int done_cyc[$];
    int viol_rw = 0, viol_rdy = 0;

    always @(negedge CLK) begin
        #2;
        cyc++;
        if (!RESET) begin
            if (bus.MEM_WRITE) begin
                w_addr.push_back(int'(bus.MEM_ADDR));
                w_data.push_back(int'(bus.MEM_DIN));
                w_cyc.push_back(cyc);
            end
            if (bus.MEM_READ) begin
                r_addr.push_back(int'(bus.MEM_ADDR));
                r_cyc.push_back(cyc);
            end
            if (bus.RDATA_VALID) begin
                d_data.push_back(int'(bus.RDATA));
                d_cyc.push_back(cyc);
            end
            if (bus.DONE) done_cyc.push_back(cyc);
            if (bus.MEM_READ && bus.MEM_WRITE) viol_rw++;
            if (bus.BUSY && bus.REQ_READY) viol_rdy++;
        end
    end

    task automatic preload();
        @(negedge CLK) pl_all = 1'b1;
        @(negedge CLK) pl_all = 1'b0;
    endtask

    task automatic run_burst(input bit wr, input int addr, input int len,
                             input bit use_pat, input logic [31:0] pat);
        int nb = len + 1;
        int wi = 0, wrc = 0, cycles = 0, ptr_err = 0;
        bit done = 1'b0;
        bit v;
        int w0 = w_addr.size(), r0 = r_addr.size(), d0 = d_data.size(), dn0 = done_cyc.size();

        @(negedge CLK);
        check("req_ready_idle", 32'(bus.REQ_READY), 1);
        bus.REQ_VALID   = 1'b1;
        bus.REQ_WR      = wr;
        bus.REQ_ADDR    = ADDR_W'(addr);
        bus.REQ_LEN     = ADDR_W'(len);
        bus.WDATA_VALID = 1'($urandom);
        bus.WDATA       = DATA_W'($urandom);

        while (!done && cycles < 200) begin
            @(negedge CLK);
            cycles++;
            if (bus.DONE) done = 1'b1;
            bus.REQ_VALID = !done && 1'($urandom);
            bus.REQ_WR    = 1'($urandom);
            bus.REQ_ADDR  = ADDR_W'($urandom);
            bus.REQ_LEN   = ADDR_W'($urandom);
            if (bus.WDATA_READY) begin
                if (int'(bus.MEM_ADDR) != (addr + wi) % DEPTH) ptr_err++;
                v = use_pat ? ((wrc < 32) ? pat[wrc] : 1'b1) : ($urandom_range(2) != 0);
                wrc++;
                bus.WDATA_VALID = v;
                bus.WDATA       = (wi < nb) ? wdata_tbl[wi] : DATA_W'($urandom);
                if (v) wi++;
            end else begin
                bus.WDATA_VALID = 1'($urandom);
                bus.WDATA       = DATA_W'($urandom);
            end
        end
        bus.REQ_VALID   = 1'b0;
        bus.WDATA_VALID = 1'b0;
        check("burst_timeout", 32'(done), 1);

        @(negedge CLK);
        check("ready_after_fin", 32'(bus.REQ_READY), 1);
        check("busy_after_fin", 32'(bus.BUSY), 0);
        repeat (RD_LAT + 3) @(negedge CLK);

        check("done_count", done_cyc.size() - dn0, 1);
        if (wr) begin
            check("wr_beats", w_addr.size() - w0, nb);
            check("wr_no_reads", r_addr.size() - r0, 0);
            check("wr_no_rdata", d_data.size() - d0, 0);
            check("wr_ptr_frozen", ptr_err, 0);
            if (w_addr.size() - w0 == nb) begin
                for (int i = 0; i < nb; i++) begin
                    check("wr_addr", w_addr[w0+i], (addr + i) % DEPTH);
                    check("wr_data", w_data[w0+i], int'(wdata_tbl[i]));
                end
                if (done_cyc.size() - dn0 == 1)
                    check("wr_done_lat", done_cyc[dn0] - w_cyc[w0+nb-1], 1);
            end
            for (int i = 0; i < nb; i++) ref_mem[(addr + i) % DEPTH] = wdata_tbl[i];
        end else begin
            check("rd_beats", r_addr.size() - r0, nb);
            check("rd_no_writes", w_addr.size() - w0, 0);
            check("rdata_count", d_data.size() - d0, nb);
            if (r_addr.size() - r0 == nb) begin
                for (int i = 0; i < nb; i++) check("rd_addr", r_addr[r0+i], (addr + i) % DEPTH);
                check("rd_consecutive", r_cyc[r0+nb-1] - r_cyc[r0], len);
            end
            if (d_data.size() - d0 == nb) begin
                for (int i = 0; i < nb; i++)
                    check("rdata", d_data[d0+i], int'(ref_mem[(addr + i) % DEPTH]));
                if (r_addr.size() - r0 == nb)
                    check("rd_latency", d_cyc[d0] - r_cyc[r0], RD_LAT + 1);
                if (done_cyc.size() - dn0 == 1)
                    check("rd_done_with_last", done_cyc[dn0], d_cyc[d0+nb-1]);
            end
        end
    endtask

    task automatic reset_mid_read();
        int seen = 0;
        int d0 = d_data.size(), dn0 = done_cyc.size();

        @(negedge CLK);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = 1'b0;
        bus.REQ_ADDR  = ADDR_W'(5);
        bus.REQ_LEN   = ADDR_W'(5);
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge CLK);
            bus.REQ_VALID = 1'b0;
            if (bus.MEM_READ) seen++;
        end
        check("rst_two_beats", seen, 2);
        @(posedge CLK);
        #1 RESET = 1'b1;
        #1 check("rst_outputs", 32'(outs), 0);
        repeat (2) @(negedge CLK);
        check("rst_outputs_hold", 32'(outs), 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_ready_after", 32'(bus.REQ_READY), 1);
        check("rst_busy_after", 32'(bus.BUSY), 0);
        repeat (6) @(negedge CLK);
        check("rst_no_rdata", d_data.size() - d0, 0);
        check("rst_no_done", done_cyc.size() - dn0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.REQ_VALID   = 1'b0;
        bus.REQ_WR      = 1'b0;
        bus.REQ_ADDR    = '0;
        bus.REQ_LEN     = '0;
        bus.WDATA       = '0;
        bus.WDATA_VALID = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'($urandom);
        preload();
        check("reset_outputs", 32'(outs), 0);
        @(negedge CLK) RESET = 1'b0;
        @(negedge CLK);
        check("ready_after_reset", 32'(bus.REQ_READY), 1);
        check("busy_after_reset", 32'(bus.BUSY), 0);

        // Single-beat write to address 3.
        wdata_tbl[0] = 8'hA5;
        run_burst(1'b1, 3, 0, 1'b1, 32'h1);

        // Wrapping read burst from 14 with known contents.
        ref_mem[14] = 8'h11; ref_mem[15] = 8'h22; ref_mem[0] = 8'h33; ref_mem[1] = 8'h44;
        preload();
        run_burst(1'b0, 14, 3, 1'b0, 32'h0);

        // Write with valid pattern 1,0,0,1,1.
        for (int i = 0; i < 3; i++) wdata_tbl[i] = DATA_W'($urandom);
        run_burst(1'b1, 6, 2, 1'b1, 32'h19);

        // Full-depth wrap: write 0..15 from 8, read back from 0.
        for (int i = 0; i < DEPTH; i++) wdata_tbl[i] = DATA_W'(i);
        run_burst(1'b1, 8, DEPTH - 1, 1'b0, 32'h0);
        run_burst(1'b0, 0, DEPTH - 1, 1'b0, 32'h0);

        reset_mid_read();

        for (int n = 0; n < 20; n++) begin
            bit wr = 1'($urandom);
            int a  = int'($urandom_range(DEPTH - 1));
            int l  = int'($urandom_range(DEPTH - 1));
            if (wr) for (int i = 0; i < DEPTH; i++) wdata_tbl[i] = DATA_W'($urandom);
            run_burst(wr, a, l, 1'b0, 32'h0);
        end

        check("rw_exclusive", viol_rw, 0);
        check("ready_while_busy", viol_rdy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
